// File: rtl/spi_slave_byte_if.sv
// Pin and stream bundle for spi_slave_byte: SPI pins plus the RX/TX valid/ready streams.
// The slave modport is the device side; the master modport is whoever drives the pins and streams.
`timescale 1ns/1ps
interface spi_slave_byte_if #(
  parameter int DATA_W = 8
);
  logic              spi_clk;
  logic              spi_csn;
  logic              spi_mosi;
  logic              spi_miso;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              overrun;
  logic              underrun;

  modport slave (
    input  spi_clk, spi_csn, spi_mosi, rx_ready, tx_data, tx_valid,
    output spi_miso, rx_data, rx_valid, tx_ready, overrun, underrun
  );

  modport master (
    output spi_clk, spi_csn, spi_mosi, rx_ready, tx_data, tx_valid,
    input  spi_miso, rx_data, rx_valid, tx_ready, overrun, underrun
  );
endinterface

// File: rtl/spi_slave_byte.sv
// SPI mode-0 slave: oversampled pins, MOSI deserialised to a valid/ready stream, MISO fed from one.
// Define SPI_SLAVE_RX_FIFO_EN to replace the single RX holding register with a FWFT FIFO.
`timescale 1ns/1ps
module spi_slave_byte #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               resetn,
  spi_slave_byte_if.slave    bus
);

  localparam int            CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_slave_byte: SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_slave_byte: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;

  // ---------------------------------------------------------------- pin sync
  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
  logic                   sclk_d, csn_d;
  logic                   sclk_s, csn_s, mosi_s;
  logic                   rise, fall, cs_start;

  // Idle levels are preloaded so reset release never looks like an edge or a select.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      // NOTE: non-blocking so each stage samples the previous stage's old value.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0],  bus.spi_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_d    <= sclk_s;
      csn_d     <= csn_s;
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_d;
  assign fall     = ~sclk_s & sclk_d;
  assign cs_start = csn_d & ~csn_s;

  // ---------------------------------------------------------------- shifter FSM
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic              word_done, word_done_n;
  logic              rx_push, rx_push_n;
  logic              tx_load;
  logic              miso_q, miso_n;
  logic              tx_ready_q, underrun_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      word_done  <= 1'b0;
      rx_push    <= 1'b0;
      miso_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rx_shift   <= rx_shift_n;
      tx_shift   <= tx_shift_n;
      word_done  <= word_done_n;
      rx_push    <= rx_push_n;
      miso_q     <= miso_n;
      tx_ready_q <= tx_load & bus.tx_valid;
      underrun_q <= tx_load & ~bus.tx_valid;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    rx_shift_n  = rx_shift;
    tx_shift_n  = tx_shift;
    word_done_n = word_done;
    rx_push_n   = 1'b0;
    tx_load     = 1'b0;

    unique case (state)
      IDLE: begin
        // A rise coinciding with cs_start is a protocol violation and is ignored here.
        if (cs_start) begin
          tx_load     = 1'b1;
          state_n     = ACTIVE;
          cnt_n       = '0;
          word_done_n = 1'b0;
        end
      end
      ACTIVE: begin
        if (csn_s) begin
          // Deselect drops any partial word and realigns the bit counter.
          state_n     = IDLE;
          cnt_n       = '0;
          word_done_n = 1'b0;
        end else if (rise) begin
          rx_shift_n = {rx_shift[DATA_W-2:0], mosi_s};
          if (cnt == LAST_BIT) begin
            cnt_n       = '0;
            word_done_n = 1'b1;
            rx_push_n   = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (fall) begin
          if (word_done) begin
            tx_load     = 1'b1;
            word_done_n = 1'b0;
          end else begin
            tx_shift_n = tx_shift << 1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (tx_load) tx_shift_n = bus.tx_valid ? bus.tx_data : '0;
    miso_n = (state_n == ACTIVE) & tx_shift_n[DATA_W-1];
  end

  assign bus.spi_miso = miso_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.underrun = underrun_q;

  // ---------------------------------------------------------------- RX storage
  // rx_push arrives one clk after the last synced rise; rx_shift holds the full word then.
  logic rx_pop;
  logic overrun_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_pop  = ~empty & bus.rx_ready;
  assign do_push = rx_push & (~full | rx_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (rx_pop)  rd_ptr <= rd_ptr + 1'b1;
      overrun_q <= rx_push & full & ~rx_pop;
    end
  end

  // NOTE: storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  // Gate the unreset storage so rx_data reads zero whenever nothing is held.
  assign bus.rx_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.rx_valid = ~empty;
`else
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;

  assign rx_pop = rx_valid_q & bus.rx_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_push) begin
        // A handshake in the same clk frees the register for the new word.
        if (!rx_valid_q || rx_pop) begin
          rx_data_q  <= rx_shift;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_pop) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`endif

  assign bus.overrun = overrun_q;

endmodule
